// File: rtl/quadrature_tracker.sv
// quadrature_tracker
//   Streams interferometer I/Q pairs in and signed position counts out.
//   Each channel goes through its own hysteresis comparator. The resulting
//   2-bit Gray code is decoded into a position count at 1x, 2x or 4x
//   resolution (COUNT_MODE). The count either wraps or clamps (SATURATE).
//
//   Pipeline (one output beat per input beat, three register levels):
//     p1  comparator bits a_q/b_q
//     p2  decode, position counter, previous code
//     p3  output register driving M_AXIS
//   Every stage advances on en = ~M_AXIS_tvalid | M_AXIS_tready.
//
//   Ports
//     aclk, areset            clock, synchronous active-high reset
//     FC_{a,b}_{lower,upper}_threshold  signed hysteresis thresholds
//     FC_position_clear       one-cycle pulse, zeroes the position
//     S_AXIS_*                {B, A} sample beat in (A = low half)
//     M_AXIS_*                signed position beat out
//     error_count/error_sticky  illegal-transition statistics
//                               (only with QUADRATURE_TRACKER_ERROR_COUNT_EN)
//
//   Optional feature macro: QUADRATURE_TRACKER_ERROR_COUNT_EN
module quadrature_tracker #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int POSITION_WIDTH   = 32,
    parameter int COUNT_MODE       = 4,
    parameter int SATURATE         = 0
) (
    input  logic                                 aclk,
    input  logic                                 areset,
    input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_a_lower_threshold,
    input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_a_upper_threshold,
    input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_b_lower_threshold,
    input  logic signed [AXIS_TDATA_WIDTH/2-1:0] FC_b_upper_threshold,
    input  logic                                 FC_position_clear,
    input  logic                                 S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]          S_AXIS_tdata,
    output logic                                 S_AXIS_tready,
    input  logic                                 M_AXIS_tready,
    output logic                                 M_AXIS_tvalid,
    output logic [POSITION_WIDTH-1:0]            M_AXIS_tdata
`ifdef QUADRATURE_TRACKER_ERROR_COUNT_EN
    ,
    output logic [15:0]                          error_count,
    output logic                                 error_sticky
`endif
);

    localparam int CH_W = AXIS_TDATA_WIDTH / 2;
    localparam logic signed [POSITION_WIDTH-1:0] POS_MAX = {1'b0, {(POSITION_WIDTH-1){1'b1}}};
    localparam logic signed [POSITION_WIDTH-1:0] POS_MIN = {1'b1, {(POSITION_WIDTH-1){1'b0}}};
    localparam logic signed [POSITION_WIDTH-1:0] POS_ONE = {{(POSITION_WIDTH-1){1'b0}}, 1'b1};

    // Hysteresis: set above hi, clear below lo, otherwise hold.
    // With inverted thresholds both can be true; set is evaluated last so it wins.
    function automatic logic hyst(input logic q,
                                  input logic signed [CH_W-1:0] x,
                                  input logic signed [CH_W-1:0] lo,
                                  input logic signed [CH_W-1:0] hi);
        logic r;
        r = q;
        if (x < lo) r = 1'b0;
        if (x > hi) r = 1'b1;
        return r;
    endfunction

    // Forward direction is 00 -> 10 -> 11 -> 01 -> 00 on {A, B}.
    function automatic logic is_fwd(input logic [1:0] old_c, input logic [1:0] new_c);
        logic r;
        case (old_c)
            2'b00:   r = (new_c == 2'b10);
            2'b10:   r = (new_c == 2'b11);
            2'b11:   r = (new_c == 2'b01);
            default: r = (new_c == 2'b00);
        endcase
        return r;
    endfunction

    // One step up or down, wrapping or clamping at the signed limits.
    function automatic logic signed [POSITION_WIDTH-1:0] step_pos(
        input logic signed [POSITION_WIDTH-1:0] pos,
        input logic up,
        input logic dn);
        logic signed [POSITION_WIDTH-1:0] r;
        r = pos;
        if (up) begin
            if (SATURATE == 0 || pos != POS_MAX) r = pos + POS_ONE;
        end else if (dn) begin
            if (SATURATE == 0 || pos != POS_MIN) r = pos - POS_ONE;
        end
        return r;
    endfunction

    logic                             en;
    logic signed [CH_W-1:0]           sample_a;
    logic signed [CH_W-1:0]           sample_b;
    logic                             a_q_p1, b_q_p1, vld_p1;
    logic [1:0]                       prev_code_p2;
    logic signed [POSITION_WIDTH-1:0] position_p2;
    logic                             vld_p2;
    logic signed [POSITION_WIDTH-1:0] tdata_p3;
    logic                             vld_p3;
    logic [1:0]                       code_p1;
    logic                             fwd, rev, a_moved, cnt_up, cnt_dn;
    logic signed [POSITION_WIDTH-1:0] position_next;

    assign en            = ~vld_p3 | M_AXIS_tready;
    assign S_AXIS_tready = en;
    assign sample_a      = S_AXIS_tdata[CH_W-1:0];
    assign sample_b      = S_AXIS_tdata[AXIS_TDATA_WIDTH-1:CH_W];

    // ---- stage p1: comparators ----
    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_p1 <= 1'b0;
            a_q_p1 <= 1'b0;
            b_q_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= S_AXIS_tvalid;
            if (S_AXIS_tvalid) begin
                a_q_p1 <= hyst(a_q_p1, sample_a, FC_a_lower_threshold, FC_a_upper_threshold);
                b_q_p1 <= hyst(b_q_p1, sample_b, FC_b_lower_threshold, FC_b_upper_threshold);
            end
        end
    end

    // ---- stage p2: decode and count ----
    always_comb begin
        code_p1 = {a_q_p1, b_q_p1};
        fwd     = is_fwd(prev_code_p2, code_p1);
        rev     = is_fwd(code_p1, prev_code_p2);
        a_moved = prev_code_p2[1] ^ code_p1[1];
        cnt_up  = 1'b0;
        cnt_dn  = 1'b0;
        case (COUNT_MODE)
            1: begin
                cnt_up = fwd && (prev_code_p2 == 2'b00);
                cnt_dn = rev && (code_p1 == 2'b00);
            end
            2: begin
                cnt_up = fwd && a_moved;
                cnt_dn = rev && a_moved;
            end
            default: begin
                cnt_up = fwd;
                cnt_dn = rev;
            end
        endcase
        position_next = step_pos(position_p2, cnt_up, cnt_dn);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_p2       <= 1'b0;
            prev_code_p2 <= 2'b00;
            position_p2  <= '0;
        end else begin
            if (en) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    prev_code_p2 <= code_p1;
                    position_p2  <= position_next;
                end
            end
            // Clear overrides the count but keeps prev_code, so the next
            // step is still decoded correctly.
            if (FC_position_clear) position_p2 <= '0;
        end
    end

    // ---- stage p3: output register ----
    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_p3   <= 1'b0;
            tdata_p3 <= '0;
        end else if (en) begin
            vld_p3 <= vld_p2;
            if (vld_p2)                 tdata_p3 <= position_p2;
            else if (FC_position_clear) tdata_p3 <= '0;
        end else if (FC_position_clear) begin
            // A beat stalled in the output register is cleared as well.
            tdata_p3 <= '0;
        end
    end

    assign M_AXIS_tvalid = vld_p3;
    assign M_AXIS_tdata  = tdata_p3;

`ifdef QUADRATURE_TRACKER_ERROR_COUNT_EN
    logic        illegal;
    logic [15:0] err_cnt_q;
    logic        err_sticky_q;

    assign illegal = ((prev_code_p2 ^ code_p1) == 2'b11);

    always_ff @(posedge aclk) begin
        if (areset || FC_position_clear) begin
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else if (en && vld_p1 && illegal) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
            err_sticky_q <= 1'b1;
        end
    end

    assign error_count  = err_cnt_q;
    assign error_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_quadrature_tracker.sv
// Testbench for quadrature_tracker: five instances with different
// COUNT_MODE / SATURATE / POSITION_WIDTH share one stimulus stream. A
// phase-based reference model predicts every output beat.
`timescale 1ns/1ps
module tb_quadrature_tracker;

    localparam int N = 5;
    localparam int PW_T   [N] = '{32, 32, 32, 8, 8};
    localparam int MODE_T [N] = '{4, 2, 1, 4, 4};
    localparam int SAT_T  [N] = '{0, 0, 0, 1, 0};

    logic               aclk = 1'b0;
    logic               areset;
    logic signed [15:0] a_lo, a_hi, b_lo, b_hi;
    logic               fc_clr;
    logic               s_vld;
    logic [31:0]        s_data;
    logic               m_rdy;

    logic               s_rdy_w  [N];
    logic               m_vld_w  [N];
    logic signed [31:0] m_data_w [N];
`ifdef QUADRATURE_TRACKER_ERROR_COUNT_EN
    logic [15:0]        err_cnt_w [N];
    logic               err_st_w  [N];
`endif

    always #5 aclk = ~aclk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int PW = PW_T[g];
        logic signed [PW-1:0] td;
        quadrature_tracker #(
            .AXIS_TDATA_WIDTH(32),
            .POSITION_WIDTH  (PW),
            .COUNT_MODE      (MODE_T[g]),
            .SATURATE        (SAT_T[g])
        ) u_dut (
            .aclk                (aclk),
            .areset              (areset),
            .FC_a_lower_threshold(a_lo),
            .FC_a_upper_threshold(a_hi),
            .FC_b_lower_threshold(b_lo),
            .FC_b_upper_threshold(b_hi),
            .FC_position_clear   (fc_clr),
            .S_AXIS_tvalid       (s_vld),
            .S_AXIS_tdata        (s_data),
            .S_AXIS_tready       (s_rdy_w[g]),
            .M_AXIS_tready       (m_rdy),
            .M_AXIS_tvalid       (m_vld_w[g]),
            .M_AXIS_tdata        (td)
`ifdef QUADRATURE_TRACKER_ERROR_COUNT_EN
            ,
            .error_count         (err_cnt_w[g]),
            .error_sticky        (err_st_w[g])
`endif
        );
        assign m_data_w[g] = 32'(td);
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Position is a walk over quadrature phases 0..3 ({A,B} = 00,10,11,01).
    // A mode-M counter counts the phase boundaries p -> p+1 where p is a
    // multiple of 4/M, in either direction.
    bit     ma, mb, mstk;
    int     mprev, merr;
    longint mpos     [N];
    longint last_out [N];
    longint expq     [N][$];

    function automatic int phase_of(input bit a, input bit b);
        if (!a && !b) return 0;
        if (a && !b)  return 1;
        if (a && b)   return 2;
        return 3;
    endfunction

    function automatic longint fit(input longint v, input int i);
        longint lim;
        lim = longint'(1) << (PW_T[i] - 1);
        if (SAT_T[i] != 0) begin
            if (v > lim - 1) return lim - 1;
            if (v < -lim)    return -lim;
            return v;
        end
        v = v & (2 * lim - 1);
        if (v >= lim) v = v - 2 * lim;
        return v;
    endfunction

    task automatic model_accept(input int sa, input int sb);
        int np, d, bnd, stp;
        if (sa > a_hi) ma = 1'b1; else if (sa < a_lo) ma = 1'b0;
        if (sb > b_hi) mb = 1'b1; else if (sb < b_lo) mb = 1'b0;
        np  = phase_of(ma, mb);
        d   = (np - mprev + 4) % 4;
        bnd = 0;
        stp = 0;
        if (d == 1) begin bnd = mprev; stp = 1;  end
        if (d == 3) begin bnd = np;    stp = -1; end
        if (d == 2) begin
            if (merr < 65535) merr++;
            mstk = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (stp != 0 && (bnd % (4 / MODE_T[i])) == 0) mpos[i] = fit(mpos[i] + stp, i);
            expq[i].push_back(mpos[i]);
        end
        mprev = np;
    endtask

    // Only used when every in-flight beat is counted no later than the clear edge.
    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            mpos[i] = 0;
            foreach (expq[i][k]) expq[i][k] = 0;
        end
        merr = 0;
        mstk = 1'b0;
    endtask

    task automatic model_reset();
        ma = 1'b0; mb = 1'b0; mprev = 0; merr = 0; mstk = 1'b0;
        for (int i = 0; i < N; i++) begin
            mpos[i] = 0;
            expq[i].delete();
        end
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic int samp(input int p, input bit chan_b);
        bit hi;
        hi = chan_b ? (p == 2 || p == 3) : (p == 1 || p == 2);
        return hi ? 1000 : -1000;
    endfunction

    // Called at a falling edge: drive, evaluate handshakes, wait one cycle.
    task automatic step(input bit v, input int sa, input int sb, input bit rdy, input bit clr, output bit acc);
        logic signed [63:0] e;
        s_vld  = v;
        s_data = {sb[15:0], sa[15:0]};
        m_rdy  = rdy;
        fc_clr = clr;
        #1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("s_ready%0d", i), s_rdy_w[i], !(m_vld_w[i] && !rdy));
            if (m_vld_w[i]) begin
                chk($sformatf("pending%0d", i), expq[i].size() != 0, 1);
                if (expq[i].size() != 0) begin
                    if (rdy) begin
                        e = expq[i].pop_front();
                        chk($sformatf("out%0d", i), m_data_w[i], e);
                        last_out[i] = m_data_w[i];
                    end else begin
                        chk($sformatf("hold%0d", i), m_data_w[i], expq[i][0]);
                    end
                end
            end
        end
        if (clr) model_clear();
        acc = v && s_rdy_w[0];
        if (acc) model_accept(sa, sb);
        @(negedge aclk);
        fc_clr = 1'b0;
    endtask

    task automatic send_ph(input int p);
        bit acc;
        step(1'b1, samp(p, 1'b0), samp(p, 1'b1), 1'b1, 1'b0, acc);
        chk("accept", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        int left;
        for (int t = 0; t < 40; t++) begin
            left = 0;
            for (int i = 0; i < N; i++) left += expq[i].size();
            if (left == 0) break;
            step(1'b0, 0, 0, 1'b1, 1'b0, acc);
        end
        left = 0;
        for (int i = 0; i < N; i++) left += expq[i].size();
        chk("drain", left, 0);
    endtask

    task automatic do_reset();
        areset = 1'b1; s_vld = 1'b0; m_rdy = 1'b1; fc_clr = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("rst_vld%0d", i), m_vld_w[i], 0);
            chk($sformatf("rst_data%0d", i), m_data_w[i], 0);
        end
        model_reset();
        areset = 1'b0;
    endtask

    task automatic set_thr(input int sel);
        case (sel)
            1:       begin a_lo = 16'sd60;   a_hi = -16'sd60;  b_lo = 16'sd60;  b_hi = -16'sd60;  end
            2:       begin a_lo = -16'sd300; a_hi = 16'sd200;  b_lo = -16'sd50; b_hi = 16'sd400;  end
            default: begin a_lo = -16'sd100; a_hi = 16'sd100;  b_lo = -16'sd100; b_hi = 16'sd100; end
        endcase
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit acc, v, rdy, pend;
        int sa, sb, ph, r, mag, k;

        s_data = '0;
        set_thr(0);
        @(negedge aclk);
        do_reset();

        // 1: three forward fringes, latency of the first beat
        for (int j = 0; j < 12; j++) begin
            if (j == 1 || j == 2) chk("latency_low", m_vld_w[0], 0);
            if (j == 3)           chk("latency_high", m_vld_w[0], 1);
            send_ph((j + 1) % 4);
        end
        drain();
        chk("fwd_x4", last_out[0], 12);
        chk("fwd_x2", last_out[1], 6);
        chk("fwd_x1", last_out[2], 3);

        // 2: three reverse fringes from zero
        step(1'b0, 0, 0, 1'b1, 1'b1, acc);
        for (int j = 0; j < 12; j++) send_ph((3 - (j % 4)) % 4);
        drain();
        chk("rev_x4", last_out[0], -12);
        chk("rev_x2", last_out[1], -6);
        chk("rev_x1", last_out[2], -3);

        // 3: A dithers inside the hysteresis band
        step(1'b0, 0, 0, 1'b1, 1'b1, acc);
        for (int j = 0; j < 100; j++) step(1'b1, (j % 2) ? 50 : -50, -1000, 1'b1, 1'b0, acc);
        drain();
        chk("dither", last_out[0], 0);

        // 4: 200 forward steps, saturating vs wrapping 8-bit counters
        step(1'b0, 0, 0, 1'b1, 1'b1, acc);
        for (int j = 0; j < 200; j++) send_ph((j + 1) % 4);
        drain();
        chk("sat8", last_out[3], 127);
        chk("wrap8", last_out[4], -56);
        chk("long_x4", last_out[0], 200);

        // 5: 10-cycle downstream stall in the middle of a burst
        k = 0;
        for (int j = 0; j < 40; j++) begin
            acc = 1'b0;
            for (int t = 0; t < 30 && !acc; t++) begin
                rdy = !(k >= 12 && k < 22);
                step(1'b1, samp((j + 1) % 4, 1'b0), samp((j + 1) % 4, 1'b1), rdy, 1'b0, acc);
                k++;
            end
            chk("accept_stall", acc, 1);
        end
        drain();
        chk("stall_x4", last_out[0], 240);
        chk("stall_sat8", last_out[3], 127);
        chk("stall_wrap8", last_out[4], -16);

        // clear while a beat is stalled in the output register
        step(1'b1, samp(1, 1'b0), samp(1, 1'b1), 1'b0, 1'b0, acc);
        for (int t = 0; t < 4; t++) step(1'b0, 0, 0, 1'b0, 1'b0, acc);
        chk("stall_vld", m_vld_w[0], 1);
        chk("stall_data", m_data_w[0], 241);
        step(1'b0, 0, 0, 1'b0, 1'b1, acc);
        chk("clr_out_data", m_data_w[0], 0);
        drain();

        // 6: illegal jump 00 -> 11, then clear together with a forward step
        send_ph(0);
        step(1'b0, 0, 0, 1'b1, 1'b1, acc);
        drain();
        send_ph(2);
        drain();
        chk("illegal_hold", last_out[0], 0);
`ifdef QUADRATURE_TRACKER_ERROR_COUNT_EN
        chk("err_count", err_cnt_w[0], 1);
        chk("err_sticky", err_st_w[0], 1);
`endif
        send_ph(3);
        step(1'b0, 0, 0, 1'b1, 1'b1, acc);
        drain();
        chk("clr_with_step", last_out[0], 0);
`ifdef QUADRATURE_TRACKER_ERROR_COUNT_EN
        chk("err_count_clr", err_cnt_w[0], 0);
        chk("err_sticky_clr", err_st_w[0], 0);
`endif

        // random traffic, thresholds and backpressure
        ph = 3; pend = 1'b0; v = 1'b0; sa = 0; sb = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 300 == 0) set_thr(int'($urandom_range(0, 2)));
            if (!pend) begin
                v   = ($urandom_range(0, 9) < 7);
                r   = int'($urandom_range(0, 9));
                mag = int'($urandom_range(500, 2000));
                if (r < 6)       ph = (ph + int'($urandom_range(0, 2)) + 3) % 4;
                else if (r == 8) ph = (ph + 2) % 4;
                sa = samp(ph, 1'b0) > 0 ? mag : -mag;
                sb = samp(ph, 1'b1) > 0 ? mag : -mag;
                if (r == 6 || r == 7) begin
                    sa = int'($urandom_range(0, 240)) - 120;
                    sb = int'($urandom_range(0, 240)) - 120;
                end
                if (r == 9) sa = int'($urandom_range(0, 40000)) - 20000;
            end
            rdy = ($urandom_range(0, 3) != 0);
            step(v, sa, sb, rdy, 1'b0, acc);
            pend = v && !acc;
        end
        drain();
`ifdef QUADRATURE_TRACKER_ERROR_COUNT_EN
        chk("rand_err_count", err_cnt_w[0], merr);
        chk("rand_err_sticky", err_st_w[0], mstk);
`endif

        // reset with beats in flight, then restart
        set_thr(0);
        for (int j = 0; j < 3; j++) send_ph(j % 4);
        do_reset();
        send_ph(1);
        send_ph(2);
        drain();
        chk("post_reset", last_out[0], 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
